eight_bit_accumulator: RTL and testbench

- Registered 8-bit accumulator that consumes the 8-bit output of the datapath operand-select mux through a valid/ready handshake.
- Each accepted transfer applies one operation (LOAD, ADD, SUB, CLR) to the accumulator, updates the flags, and presents the result downstream with a valid/ready handshake.
- Forms the sequential execute stage directly after the operand-select stage.

---
 rtl/eight_bit_accumulator_if.sv | 23 ++
 rtl/eight_bit_accumulator.sv | 111 +++++++++++
 tb/tb_eight_bit_accumulator.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/eight_bit_accumulator_if.sv
// rtl/eight_bit_accumulator_if.sv - operand/op input and result output handshake bundle
interface eight_bit_accumulator_if;
  logic [7:0] in_data;
  logic [1:0] in_op;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] acc;
  logic       carry;
  logic       overflow;
  logic       zero;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_op, in_valid, out_ready,
    input  in_ready, acc, carry, overflow, zero, out_valid
  );

  modport slave (
    input  in_data, in_op, in_valid, out_ready,
    output in_ready, acc, carry, overflow, zero, out_valid
  );
endinterface

// File: rtl/eight_bit_accumulator.sv
// rtl/eight_bit_accumulator.sv - registered 8-bit accumulator execute stage with LOAD/ADD/SUB/CLR
module eight_bit_accumulator #(
  parameter logic [7:0] RESET_VALUE = 8'h00
) (
  input logic                  clk,
  input logic                  reset_n,
  eight_bit_accumulator_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  state_t     state;
  logic [7:0] data_q;
  logic [1:0] op_q;
  logic [7:0] acc_q;
  logic       carry_q;
  logic       overflow_q;
  logic       zero_q;
  logic       in_ready_q;
  logic       out_valid_q;

  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] next_acc;
  logic       next_carry;
  logic       next_overflow;

  // 9-bit arithmetic: bit 8 is carry-out for ADD and borrow for SUB.
  always_comb begin
    sum9          = {1'b0, acc_q} + {1'b0, data_q};
    diff9         = {1'b0, acc_q} - {1'b0, data_q};
    next_acc      = 8'h00;
    next_carry    = 1'b0;
    next_overflow = 1'b0;
    case (op_q)
      OP_LOAD: next_acc = data_q;
      OP_ADD: begin
        next_acc      = sum9[7:0];
        next_carry    = sum9[8];
        next_overflow = (acc_q[7] == data_q[7]) && (sum9[7] != acc_q[7]);
      end
      OP_SUB: begin
        next_acc      = diff9[7:0];
        next_carry    = diff9[8];
        next_overflow = (acc_q[7] != data_q[7]) && (diff9[7] != acc_q[7]);
      end
      default: next_acc = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      data_q      <= 8'h00;
      op_q        <= 2'b00;
      acc_q       <= RESET_VALUE;
      carry_q     <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= (RESET_VALUE == 8'h00);
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            data_q     <= bus.in_data;
            op_q       <= bus.in_op;
            in_ready_q <= 1'b0;
            state      <= EXEC;
          end
        end
        EXEC: begin
          acc_q       <= next_acc;
          carry_q     <= next_carry;
          overflow_q  <= next_overflow;
          zero_q      <= (next_acc == 8'h00);
          out_valid_q <= 1'b1;
          state       <= DONE;
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.acc       = acc_q;
  assign bus.carry     = carry_q;
  assign bus.overflow  = overflow_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_eight_bit_accumulator.sv
// tb/tb_eight_bit_accumulator.sv - scoreboard bench with randomized ops against an arithmetic reference model
module tb_eight_bit_accumulator;

  logic clk;
  logic reset_n;

  eight_bit_accumulator_if bus ();

  eight_bit_accumulator #(.RESET_VALUE(8'h00)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] acc;
    logic       carry;
    logic       overflow;
    logic       zero;
  } result_t;

  result_t    expq[$];
  logic [7:0] model_acc;
  int         checks;
  int         passes;
  int         bp_mode;   // 0 random out_ready, 1 held low, 2 held high

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
  endtask

  function automatic int to_signed(input logic [7:0] v);
    return (v >= 8'd128) ? int'(v) - 256 : int'(v);
  endfunction

  // Reference model: unsigned and signed results computed as plain integers.
  function automatic result_t model_step(input logic [1:0] op, input logic [7:0] d);
    result_t r;
    int u, s;
    r.carry = 1'b0;
    r.overflow = 1'b0;
    case (op)
      2'd0: r.acc = d;
      2'd1: begin
        u = int'(model_acc) + int'(d);
        s = to_signed(model_acc) + to_signed(d);
        r.acc = u[7:0];
        r.carry = (u > 255);
        r.overflow = (s > 127) || (s < -128);
      end
      2'd2: begin
        u = int'(model_acc) - int'(d);
        s = to_signed(model_acc) - to_signed(d);
        r.acc = u[7:0];
        r.carry = (u < 0);
        r.overflow = (s > 127) || (s < -128);
      end
      default: r.acc = 8'h00;
    endcase
    r.zero = (r.acc == 8'h00);
    return r;
  endfunction

  task automatic send(input logic [1:0] op, input logic [7:0] d);
    int cnt;
    result_t r;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_op    = op;
    cnt = 0;
    while (!bus.in_ready && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) begin
      chk("send_timeout", 32'd1, 32'd0);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      r = model_step(op, d);
      model_acc = r.acc;
      expq.push_back(r);
      #1;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      bus.in_op    = 2'($urandom);
    end
  endtask

  task automatic drain();
    int cnt;
    cnt = 0;
    while ((expq.size() != 0 || bus.out_valid) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 100) chk("drain_timeout", 32'd1, 32'd0);
  endtask

  // Monitor: compares every cycle a result is presented, pops on handshake.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_result", 32'd1, 32'd0);
        end else begin
          chk("acc", 32'(bus.acc), 32'(expq[0].acc));
          chk("carry", 32'(bus.carry), 32'(expq[0].carry));
          chk("overflow", 32'(bus.overflow), 32'(expq[0].overflow));
          chk("zero", 32'(bus.zero), 32'(expq[0].zero));
        end
      end
      case (bp_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      if (bus.out_valid && bus.out_ready && expq.size() != 0) void'(expq.pop_front());
    end
  end

  initial begin
    checks = 0;
    passes = 0;
    bp_mode = 2;
    model_acc = 8'h00;
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.in_op = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_acc", 32'(bus.acc), 32'h00);
    chk("rst_zero", 32'(bus.zero), 32'd1);
    chk("rst_carry", 32'(bus.carry), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    reset_n = 1'b1;

    // Latency: EXEC cycle, then one DONE cycle, then back to IDLE.
    send(2'd0, 8'h3C);
    @(negedge clk);
    chk("lat_exec_out_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_exec_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    chk("lat_done_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_done_acc", 32'(bus.acc), 32'h3C);
    chk("lat_done_zero", 32'(bus.zero), 32'd0);
    @(negedge clk);
    chk("lat_idle_out_valid", 32'(bus.out_valid), 32'd0);
    chk("lat_idle_in_ready", 32'(bus.in_ready), 32'd1);

    // Directed arithmetic corner cases.
    send(2'd0, 8'hF0);
    send(2'd1, 8'h20);
    drain();
    chk("add_wrap_acc", 32'(bus.acc), 32'h10);
    chk("add_wrap_carry", 32'(bus.carry), 32'd1);
    chk("add_wrap_ovf", 32'(bus.overflow), 32'd0);
    send(2'd1, 8'h70);
    drain();
    chk("add_ovf_acc", 32'(bus.acc), 32'h80);
    chk("add_ovf_carry", 32'(bus.carry), 32'd0);
    chk("add_ovf_ovf", 32'(bus.overflow), 32'd1);
    send(2'd0, 8'h05);
    send(2'd2, 8'h07);
    drain();
    chk("sub_borrow_acc", 32'(bus.acc), 32'hFE);
    chk("sub_borrow_carry", 32'(bus.carry), 32'd1);
    chk("sub_borrow_ovf", 32'(bus.overflow), 32'd0);
    send(2'd2, 8'hFE);
    drain();
    chk("sub_zero_acc", 32'(bus.acc), 32'h00);
    chk("sub_zero_zero", 32'(bus.zero), 32'd1);
    chk("sub_zero_carry", 32'(bus.carry), 32'd0);
    send(2'd0, 8'h80);
    send(2'd1, 8'hFF);
    drain();
    chk("pre_clr_acc", 32'(bus.acc), 32'h7F);
    chk("pre_clr_carry", 32'(bus.carry), 32'd1);
    send(2'd3, 8'hFF);
    drain();
    chk("clr_acc", 32'(bus.acc), 32'h00);
    chk("clr_carry", 32'(bus.carry), 32'd0);
    chk("clr_ovf", 32'(bus.overflow), 32'd0);
    chk("clr_zero", 32'(bus.zero), 32'd1);

    // Backpressure: result held, second pair waits until DONE releases.
    bp_mode = 1;
    send(2'd0, 8'h5A);
    fork
      send(2'd1, 8'h11);
    join_none
    repeat (6) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk);
    #1 bp_mode = 2;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bp_not_yet_accepted", 32'(expq.size()), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("bp_accepted_next", 32'(expq.size()), 32'd1);
    wait fork;
    drain();
    chk("bp_second_acc", 32'(bus.acc), 32'h6B);

    // Asynchronous reset while a result is held in DONE.
    send(2'd0, 8'h80);
    drain();
    bp_mode = 1;
    send(2'd1, 8'hFF);
    begin
      int cnt;
      cnt = 0;
      while (!bus.out_valid && cnt < 20) begin
        @(negedge clk);
        cnt++;
      end
      chk("reset_wait_done", 32'(bus.out_valid), 32'd1);
    end
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_acc", 32'(bus.acc), 32'h00);
    chk("async_rst_zero", 32'(bus.zero), 32'd1);
    chk("async_rst_carry", 32'(bus.carry), 32'd0);
    chk("async_rst_ovf", 32'(bus.overflow), 32'd0);
    chk("async_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    expq.delete();
    model_acc = 8'h00;
    @(negedge clk);
    reset_n = 1'b1;
    bp_mode = 0;

    // Randomized traffic with random downstream backpressure.
    for (int i = 0; i < 200; i++) begin
      send(2'($urandom_range(0, 3)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    bp_mode = 2;
    drain();
    chk("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
